// File: rtl/b_dly_cal.sv
// Calibration controller for a 2^DW-tap delay line: binary-search lock from a
// phase-detector vote, then optional +/-1 drift tracking with saturation.
module b_dly_cal #(
  parameter int DW     = 9,
  parameter int SETTLE = 8,
  parameter int AVG    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_track_en,
  input  logic          i_pd_lead,
  output logic [DW-1:0] o_dly_sel,
  output logic          o_busy,
  output logic          o_locked,
  output logic          o_cal_err
);

  localparam int WIN = SETTLE + AVG;
  localparam int WCW = $clog2(WIN);
  localparam int CW  = $clog2(AVG + 1);
  localparam int IW  = $clog2(DW);

  localparam logic [WCW-1:0] WIN_LAST  = WCW'(WIN - 1);
  localparam logic [WCW-1:0] SETTLE_C  = WCW'(SETTLE);
  localparam logic [CW-1:0]  HALF      = CW'(AVG / 2);
  localparam logic [DW-1:0]  MID       = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]  SEL_MAX   = '1;
  localparam logic [IW-1:0]  IDX_TOP   = IW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, TRACK} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  sel_q, sel_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [WCW-1:0] win_q, win_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           locked_q, locked_d;
  logic           err_q, err_d;

  logic           sampling;
  logic           win_end;
  logic [CW-1:0]  vote;
  logic           lead;
  logic           lag;
  logic [DW-1:0]  trial;
  logic [IW-1:0]  idx_m1;

  // Window timebase and vote: the last sample is folded in combinationally so
  // the decision lands on the same edge that captures it.
  always_comb begin
    sampling = (win_q >= SETTLE_C);
    win_end  = (win_q == WIN_LAST);
    vote     = cnt_q + CW'(sampling & i_pd_lead);
    lead     = (vote > HALF);
    lag      = (vote < HALF);
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    err_d    = err_q;
    trial    = sel_q;
    idx_m1   = idx_q - 1'b1;

    if (state_q != IDLE) begin
      if (win_end) begin
        win_d = '0;
        cnt_d = '0;
      end else begin
        win_d = win_q + 1'b1;
        cnt_d = vote;
      end
    end

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          sel_d    = MID;
          idx_d    = IDX_TOP;
          busy_d   = 1'b1;
          locked_d = 1'b0;
          err_d    = 1'b0;
          win_d    = '0;
          cnt_d    = '0;
          state_d  = SEARCH;
        end
      end

      SEARCH: begin
        if (win_end) begin
          trial[idx_q] = lead;
          if (idx_q != '0) begin
            trial[idx_m1] = 1'b1;
            idx_d         = idx_m1;
          end else begin
            locked_d = 1'b1;
            err_d    = (trial == '0) || (trial == SEL_MAX);
            if (i_track_en) begin
              state_d = TRACK;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
          sel_d = trial;
        end
      end

      TRACK: begin
        if (win_end) begin
          if (lead) begin
            if (sel_q == SEL_MAX) err_d = 1'b1;
            else                  sel_d = sel_q + 1'b1;
          end else if (lag) begin
            if (sel_q == '0) err_d = 1'b1;
            else             sel_d = sel_q - 1'b1;
          end
          // A start arriving on this exit edge is dropped: it is only seen in IDLE.
          if (!i_track_en) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      idx_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign o_dly_sel = sel_q;
  assign o_busy    = busy_q;
  assign o_locked  = locked_q;
  assign o_cal_err = err_q;

endmodule

// File: tb/tb_b_dly_cal.sv
// Directed bench for b_dly_cal: a scoreboard of expected select changes (value
// and cycle) is filled when a start is driven and drained by a select monitor.
`timescale 1ns/1ps
module tb_b_dly_cal;

  localparam int DW   = 9;
  localparam int WIN  = 12;
  localparam int LOCK = DW * WIN;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          track_en;
  logic          pd_lead;
  logic [DW-1:0] dly_sel;
  logic          busy;
  logic          locked;
  logic          cal_err;

  b_dly_cal #(.DW(DW), .SETTLE(8), .AVG(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_track_en (track_en),
    .i_pd_lead  (pd_lead),
    .o_dly_sel  (dly_sel),
    .o_busy     (busy),
    .o_locked   (locked),
    .o_cal_err  (cal_err)
  );

  typedef struct {
    logic [DW-1:0] sel;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            mode = 0;   // 0 threshold, 1 held high, 2 held low, 3 toggle
  int            thr = 300;
  logic          mon_en = 1'b0;
  logic [DW-1:0] prev_sel = '0;
  int            c0;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Phase-detector model, updated away from the sampling edge.
  initial begin
    pd_lead = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       pd_lead = (dly_sel <= thr);
        1:       pd_lead = 1'b1;
        2:       pd_lead = 1'b0;
        default: pd_lead = ~pd_lead;
      endcase
    end
  end

  // Every observed select change must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (dly_sel !== prev_sel) begin
      if (mon_en) begin
        if (sb.size() == 0) begin
          check("unexpected_sel_change", dly_sel, prev_sel);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sel_value", dly_sel, e.sel);
          check("sel_cycle", cyc, e.cyc);
        end
      end
      prev_sel = dly_sel;
    end
  end

  task automatic push(input int sel, input int at);
    exp_t e;
    e.sel = DW'(sel);
    e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic push_seq_300(input int base);
    int s[10] = '{256, 384, 320, 288, 304, 296, 300, 302, 301, 300};
    for (int k = 0; k < 10; k++) push(s[k], base + WIN * k);
  endtask

  task automatic push_search_const(input int base, input bit lead_v);
    logic [DW-1:0] t;
    int            b;
    t = '0;
    t[DW-1] = 1'b1;
    for (int k = 0; k < DW; k++) begin
      push(int'(t), base + WIN * k);
      b = DW - 1 - k;
      if (!lead_v) t[b] = 1'b0;
      if (b > 0) t[b-1] = 1'b1;
    end
    if (!lead_v) push(int'(t), base + LOCK);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_lock(input int base);
    int i;
    i = 0;
    while (locked !== 1'b1 && i < 400) begin
      @(negedge clk);
      i++;
    end
    check("lock_cycle", cyc, base + LOCK);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    track_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sel", dly_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_locked", locked, 0);
    check("rst_err", cal_err, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("idle_sel", dly_sel, 0);
    check("idle_busy", busy, 0);
    check("idle_locked", locked, 0);
    check("idle_err", cal_err, 0);
    mon_en = 1'b1;

    // Asynchronous reset in the middle of a search, at trial 288.
    mode = 0; thr = 300;
    c0 = cyc + 1;
    push(256, c0); push(384, c0 + 12); push(320, c0 + 24); push(288, c0 + 36);
    start_pulse();
    wait_until(c0 + 40);
    check("pre_reset_sel", dly_sel, 288);
    check("pre_reset_busy", busy, 1);
    check("pre_reset_sb_empty", sb.size(), 0);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_sel", dly_sel, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_locked", locked, 0);
    check("async_rst_err", cal_err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    // Search against threshold 300, no tracking.
    c0 = cyc + 1;
    push_seq_300(c0);
    start_pulse();
    check("search_busy", busy, 1);
    wait_lock(c0);
    check("s300_sel", dly_sel, 300);
    check("s300_busy", busy, 0);
    check("s300_locked", locked, 1);
    check("s300_err", cal_err, 0);
    check("s300_sb_empty", sb.size(), 0);

    // Detector held high: pinned at the top.
    mode = 1;
    c0 = cyc + 1;
    push_search_const(c0, 1'b1);
    start_pulse();
    check("start_clears_locked", locked, 0);
    wait_lock(c0);
    check("hi_sel", dly_sel, 511);
    check("hi_err", cal_err, 1);
    check("hi_busy", busy, 0);

    // Detector held low: pinned at the bottom.
    mode = 2;
    c0 = cyc + 1;
    push_search_const(c0, 1'b0);
    start_pulse();
    check("start_clears_err", cal_err, 0);
    wait_lock(c0);
    check("lo_sel", dly_sel, 0);
    check("lo_err", cal_err, 1);
    check("lo_sb_empty", sb.size(), 0);

    // Tracking: lock at 300, then the threshold drifts to 305.
    mode = 0; thr = 300; track_en = 1'b1;
    c0 = cyc + 1;
    push_seq_300(c0);
    start_pulse();
    wait_lock(c0);
    check("trk_busy", busy, 1);
    check("trk_locked", locked, 1);
    thr = 305;
    for (int k = 1; k <= 5; k++) push(300 + k, c0 + LOCK + WIN * k);
    push(306, c0 + 180); push(305, c0 + 192); push(306, c0 + 204);
    push(305, c0 + 216); push(306, c0 + 228);
    wait_until(c0 + 220);
    track_en = 1'b0;
    wait_until(c0 + 228);
    check("trk_exit_busy", busy, 0);
    check("trk_exit_locked", locked, 1);
    check("trk_exit_sel", dly_sel, 306);
    check("trk_exit_err", cal_err, 0);
    repeat (30) @(negedge clk);
    check("trk_sb_empty", sb.size(), 0);

    // Tie votes hold the select while tracking.
    mode = 0; thr = 300; track_en = 1'b1;
    c0 = cyc + 1;
    push_seq_300(c0);
    start_pulse();
    wait_lock(c0);
    mode = 3;
    wait_until(c0 + LOCK + 48);
    check("tie_trk_sel", dly_sel, 300);
    check("tie_trk_busy", busy, 1);
    track_en = 1'b0;
    begin
      int i;
      i = 0;
      while (busy === 1'b1 && i < 30) begin
        @(negedge clk);
        i++;
      end
    end
    check("tie_exit_busy", busy, 0);
    check("tie_exit_sel", dly_sel, 300);

    // Tie votes during search clear every bit.
    c0 = cyc + 1;
    push_search_const(c0, 1'b0);
    start_pulse();
    wait_lock(c0);
    check("tie_search_sel", dly_sel, 0);
    check("tie_search_err", cal_err, 1);

    // A start while searching is ignored.
    mode = 0; thr = 300; track_en = 1'b0;
    c0 = cyc + 1;
    push_seq_300(c0);
    start_pulse();
    wait_until(c0 + 40);
    start_pulse();
    wait_lock(c0);
    check("ign_search_sel", dly_sel, 300);
    check("ign_search_sb_empty", sb.size(), 0);

    // A start while tracking, and on the tracking exit edge, is ignored.
    track_en = 1'b1;
    c0 = cyc + 1;
    push_seq_300(c0);
    start_pulse();
    wait_lock(c0);
    mode = 3;
    wait_until(c0 + 115);
    start_pulse();
    wait_until(c0 + 125);
    track_en = 1'b0;
    wait_until(c0 + 131);
    start_pulse();
    check("ign_exit_busy", busy, 0);
    check("ign_exit_locked", locked, 1);
    repeat (5) @(negedge clk);
    check("ign_norestart_busy", busy, 0);
    check("ign_norestart_locked", locked, 1);
    check("ign_norestart_sel", dly_sel, 300);

    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/b_dly_cal.md
Name: b_dly_cal

Overview:
- Calibration controller for the 512-tap delay line: a fine stage of 64 steps and a coarse stage of 8 steps, with a 9-bit delay select.
- Drives the delay line's 9-bit select from a phase-detector verdict. The detector compares the delayed clock against a reference.
- Runs a 9-step binary search to acquire lock, then optionally tracks drift with ±1 steps.
- Sits directly upstream of the delay line; o_dly_sel connects straight to the delay line's i_dly_sel.

Parameters:
- DW, 9, select width; 2^DW taps.
- SETTLE, 8, clock cycles waited after each select change before sampling starts (min 1).
- AVG, 4, phase-detector samples per decision (even, min 2).

Ports:
- i_clk  input  1  controller clock
- i_rst  input  1  asynchronous reset, active-high
- i_start  input  1  one-cycle pulse; starts calibration when idle
- i_track_en  input  1  1 = enter tracking after the search completes
- i_pd_lead  input  1  phase-detector verdict; 1 = delayed clock early, so more delay is needed
- o_dly_sel  output  DW  delay select to the delay line
- o_busy  output  1  calibration or tracking in progress
- o_locked  output  1  binary search has completed since the last start
- o_cal_err  output  1  result pinned at a range limit

Behaviour:
- Reset (async, any time, including mid-operation): o_dly_sel=0, o_busy=0, o_locked=0, o_cal_err=0, state IDLE, all counters 0.
- All outputs are registered. Timebase is one decision window = SETTLE cycles of settling followed by AVG cycles of sampling.
- During the window, a vote counter cnt counts cycles with i_pd_lead=1, sampled only in the AVG phase.
- The decision is registered on the edge that captures the last sample:
  - LEAD: cnt > AVG/2
  - LAG: cnt < AVG/2
  - TIE: cnt = AVG/2
- States: IDLE, SEARCH, TRACK.
- IDLE:
  - o_busy=0.
  - When i_start=1 at an edge: next cycle o_dly_sel=2^(DW-1) (256), bit index=DW-1, o_busy=1, o_locked=0, o_cal_err=0; go to SEARCH.
- SEARCH:
  - At each window end, the current trial bit is kept on LEAD and cleared on LAG or TIE.
  - If index>0, the same edge sets bit index-1 and decrements index.
  - After bit 0 is decided: o_locked=1; o_cal_err=1 if the result is 0 or 2^DW-1.
  - Then go to TRACK if i_track_en=1; otherwise go to IDLE with o_busy=0.
  - Search latency: DW*(SETTLE+AVG) cycles after the first SEARCH cycle (108 at defaults).
- TRACK:
  - At each window end: LEAD increments o_dly_sel; LAG decrements it; TIE holds it.
  - Saturate at 2^DW-1 and 0, with no wrap.
  - A LEAD at 2^DW-1, or a LAG at 0, sets o_cal_err=1. o_cal_err is sticky until the next start or reset.
  - i_track_en is sampled only at the window end; if it is 0, go to IDLE, o_busy=0, o_locked stays 1.
- i_start while o_busy=1 is ignored.
- i_start coinciding with the TRACK exit edge is also ignored.
- After every o_dly_sel change, the settle counter restarts from 0.
- The select never changes outside a window-end edge, except for the load edge on start.
- i_pd_lead is treated as synchronous to i_clk; synchronisation is the detector's responsibility.

Test Plan:
- Reset, then release with no start -> all outputs 0 indefinitely. Assert i_rst mid-SEARCH at select 288 -> outputs 0 immediately (asynchronous), without waiting for a clock edge.
- Detector model lead=(o_dly_sel<=300), i_track_en=0, pulse i_start:
  - trial sequence 256, 384, 320, 288, 304, 296, 300, 302, 301;
  - final o_dly_sel=300, o_locked=1 and o_busy=0 exactly 108 cycles after the SEARCH entry cycle, o_cal_err=0.
- Detector held at 1 -> result 511, o_cal_err=1. Detector held at 0 -> result 0, o_cal_err=1.
- i_track_en=1, lock at 300, then move the model threshold to 305:
  - o_dly_sel steps +1 every 12 cycles to 305, then dithers between 305 and 306;
  - deassert i_track_en -> IDLE at the next window end, o_locked=1.
- Detector toggling 1/0 each cycle (cnt=2, a TIE):
  - TRACK holds o_dly_sel constant;
  - a fresh SEARCH yields 0 with o_cal_err=1.
- Pulse i_start while in SEARCH and while in TRACK -> no restart; the trial sequence and timing are unchanged.
